// File: rtl/alu_issue.sv
// alu_issue: decode/issue/writeback stage ahead of the ALU; optional divide-by-zero trap under ALU_DIVZERO_TRAP_EN
module alu_issue #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NREGS_LOG2     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  output logic                  in_alu,
  output logic [31:0]           operand1,
  output logic [31:0]           operand2,
  output logic [5:0]            operation,
  output logic [5:0]            op,
  output logic [4:0]            shamt,
  input  logic [31:0]           alu_result,
  input  logic                  out_alu,
  output logic                  retire,
  output logic [NREGS_LOG2-1:0] retire_rd,
  output logic [31:0]           retire_data,
  output logic                  err_illegal,
  output logic                  err_timeout,
  output logic                  err_divzero,
  input  logic [NREGS_LOG2-1:0] dbg_addr,
  output logic [31:0]           dbg_data
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  state_t state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [NREGS_LOG2-1:0] dest_q, dest_d;
  logic in_alu_q, in_alu_d;
  logic [31:0] operand1_q, operand1_d, operand2_q, operand2_d;
  logic [5:0] operation_q, operation_d, op_q, op_d;
  logic [4:0] shamt_q, shamt_d;
  logic [15:0] wd_q, wd_d;
  logic retire_q, retire_d;
  logic [NREGS_LOG2-1:0] retire_rd_q, retire_rd_d;
  logic [31:0] retire_data_q, retire_data_d;
  logic err_illegal_q, err_illegal_d, err_timeout_q, err_timeout_d, err_divzero_q, err_divzero_d;
  logic [31:0] rf_q [2**NREGS_LOG2];
  logic [5:0] opc, funct;
  logic [NREGS_LOG2-1:0] rs, rt, rd;
  logic [31:0] rs_val, rt_val, imm_sx;
  logic is_r, legal, divz;
  assign opc    = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign funct  = instr_q[5:0];
  assign imm_sx = {{16{instr_q[15]}}, instr_q[15:0]};
  assign rs_val = rf_q[rs];
  assign rt_val = rf_q[rt];
  assign is_r   = opc == 6'b000000;
  assign legal  = is_r ? (funct >= 6'd1 && funct <= 6'd13) : (opc == 6'b001000);
`ifdef ALU_DIVZERO_TRAP_EN
  assign divz = is_r && funct == 6'b001100 && rt_val == 32'd0;
`else
  assign divz = 1'b0;
`endif
  assign instr_ready = state_q == IDLE;
  assign in_alu      = in_alu_q;
  assign operand1    = operand1_q;
  assign operand2    = operand2_q;
  assign operation   = operation_q;
  assign op          = op_q;
  assign shamt       = shamt_q;
  assign retire      = retire_q;
  assign retire_rd   = retire_rd_q;
  assign retire_data = retire_data_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign err_divzero = err_divzero_q;
  assign dbg_data    = dbg_addr == '0 ? 32'd0 : rf_q[dbg_addr];
  // next-state and registered-output logic; pulses default low, everything else holds
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    dest_d        = dest_q;
    in_alu_d      = in_alu_q;
    operand1_d    = operand1_q;
    operand2_d    = operand2_q;
    operation_d   = operation_q;
    op_d          = op_q;
    shamt_d       = shamt_q;
    wd_d          = wd_q;
    retire_d      = 1'b0;
    retire_rd_d   = retire_rd_q;
    retire_data_d = retire_data_q;
    err_illegal_d = 1'b0;
    err_timeout_d = 1'b0;
    err_divzero_d = 1'b0;
    case (state_q)
      IDLE: begin
        instr_d = instr_valid ? instr : instr_q;
        state_d = instr_valid ? DECODE : IDLE;
      end
      DECODE: begin
        err_illegal_d = !legal;
        err_divzero_d = legal && divz;
        state_d       = (legal && !divz) ? EXEC : IDLE;
        if (legal && !divz) begin
          in_alu_d    = 1'b1;
          operand1_d  = rs_val;
          operand2_d  = is_r ? rt_val : imm_sx;
          operation_d = is_r ? funct : 6'b001101;
          op_d        = opc;
          shamt_d     = instr_q[10:6];
          dest_d      = is_r ? rd : rt;
          wd_d        = 16'd0;
        end
      end
      EXEC: begin
        if (out_alu) begin
          in_alu_d      = 1'b0;
          retire_d      = 1'b1;
          retire_rd_d   = dest_q;
          retire_data_d = alu_result;
          state_d       = WB;
        end else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
          in_alu_d      = 1'b0;
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state, output registers and register-file writeback (r0 never written)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      dest_q        <= '0;
      in_alu_q      <= 1'b0;
      operand1_q    <= '0;
      operand2_q    <= '0;
      operation_q   <= '0;
      op_q          <= '0;
      shamt_q       <= '0;
      wd_q          <= '0;
      retire_q      <= 1'b0;
      retire_rd_q   <= '0;
      retire_data_q <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      err_divzero_q <= 1'b0;
      for (int i = 0; i < 2**NREGS_LOG2; i++) rf_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      dest_q        <= dest_d;
      in_alu_q      <= in_alu_d;
      operand1_q    <= operand1_d;
      operand2_q    <= operand2_d;
      operation_q   <= operation_d;
      op_q          <= op_d;
      shamt_q       <= shamt_d;
      wd_q          <= wd_d;
      retire_q      <= retire_d;
      retire_rd_q   <= retire_rd_d;
      retire_data_q <= retire_data_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
      err_divzero_q <= err_divzero_d;
      if (state_q == WB && retire_rd_q != '0) rf_q[retire_rd_q] <= retire_data_q;
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized scoreboard bench for alu_issue with a behavioural ALU stand-in
module tb_alu_issue;
  localparam int TO = 20;
  logic clk, rst, instr_valid, instr_ready, in_alu, out_alu, retire;
  logic err_illegal, err_timeout, err_divzero;
  logic [31:0] instr, operand1, operand2, alu_result, retire_data, dbg_data;
  logic [5:0] operation, op;
  logic [4:0] shamt, retire_rd, dbg_addr;
  logic alu_o, stray;
  int cyc, checks, errors, alu_lat, acnt, ia_cnt;
  bit fired;
  logic [31:0] m [32];
  typedef struct {
    logic [3:0]  kind;
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
    int          ia;
    logic [75:0] ops;
  } exp_t;
  exp_t q[$];
  localparam logic [3:0] K_RET = 4'b1000, K_ILL = 4'b0100, K_TO = 4'b0010, K_DZ = 4'b0001;

  alu_issue #(.TIMEOUT_CYCLES(TO), .NREGS_LOG2(5)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .in_alu(in_alu), .operand1(operand1), .operand2(operand2), .operation(operation), .op(op),
    .shamt(shamt), .alu_result(alu_result), .out_alu(out_alu), .retire(retire),
    .retire_rd(retire_rd), .retire_data(retire_data), .err_illegal(err_illegal),
    .err_timeout(err_timeout), .err_divzero(err_divzero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign out_alu = alu_o | stray;

  function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    return f == 6'd13 ? a + b : f == 6'd12 ? a / b : a ^ b ^ {26'd0, f};
  endfunction

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // registered ALU stand-in: answers alu_lat+1 cycles after seeing in_alu, never for divide by zero
  initial begin
    alu_o = 1'b0;
    alu_result = '0;
    acnt = 0;
    fired = 0;
    forever begin
      @(posedge clk);
      #1;
      alu_o = 1'b0;
      if (!in_alu || rst) begin
        acnt = 0;
        fired = 0;
      end else if (!fired && !(operation == 6'd12 && operand2 == 32'd0)) begin
        if (acnt == alu_lat + 1) begin
          alu_o = 1'b1;
          alu_result = ref_alu(operation, operand1, operand2);
          fired = 1;
        end else acnt++;
      end
    end
  end

  // monitor: checks issued operands and pops one expectation per outcome pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst) ia_cnt = 0;
    else begin
      if (in_alu) begin
        ia_cnt++;
        if (ia_cnt == 1) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: in_alu high with nothing pending (cycle %0d)", cyc);
          end else chk("operands", {operation, op, operand1, operand2}, q[0].ops);
        end
      end
      if (retire | err_illegal | err_timeout | err_divzero) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got %b expected none (cycle %0d)",
                   {retire, err_illegal, err_timeout, err_divzero}, cyc);
        end else begin
          e = q.pop_front();
          chk("kind", {retire, err_illegal, err_timeout, err_divzero}, e.kind);
          chk("cycle", cyc, e.cyc);
          chk("in_alu_cycles", ia_cnt, e.ia);
          chk("instr_ready", instr_ready, e.kind != K_RET);
          if (e.kind == K_RET) chk("retire_rd_data", {retire_rd, retire_data}, {e.rd, e.data});
          ia_cnt = 0;
        end
      end
    end
  end

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int f);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(f)};
  endfunction

  function automatic logic [31:0] itype(input int o, input int rs, input int rt, input int imm);
    return {6'(o), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic issue(input logic [31:0] ins, input int lat);
    exp_t e;
    int t = 0;
    logic [5:0] o, f;
    logic [31:0] a, b;
    logic [4:0] d;
    while (!instr_ready && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: instr_ready still 0 after %0d cycles", t);
      return;
    end
    o = ins[31:26];
    f = ins[5:0];
    a = m[ins[25:21]];
    b = o == 6'd0 ? m[ins[20:16]] : {{16{ins[15]}}, ins[15:0]};
    d = o == 6'd0 ? ins[15:11] : ins[20:16];
    e = '{kind: K_ILL, cyc: cyc + 2, rd: 5'd0, data: 32'd0, ia: 0, ops: '0};
    if ((o == 6'd0 && f >= 6'd1 && f <= 6'd13) || o == 6'd8) begin
      e.ops = {o == 6'd0 ? f : 6'd13, o, a, b};
      if (o == 6'd0 && f == 6'd12 && b == 32'd0) begin
`ifdef ALU_DIVZERO_TRAP_EN
        e.kind = K_DZ;
`else
        e.kind = K_TO;
        e.cyc = cyc + 2 + TO;
        e.ia = TO;
`endif
      end else begin
        e.kind = K_RET;
        e.cyc = cyc + 4 + lat;
        e.ia = 2 + lat;
        e.rd = d;
        e.data = ref_alu(e.ops[75:70], a, b);
        if (d != 5'd0) m[d] = e.data;
      end
    end
    q.push_back(e);
    alu_lat = lat;
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d outcomes still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 32; i++) m[i] = '0;
    chk("reset_outputs", {in_alu, operand1, operand2, operation, op, shamt, retire, retire_rd,
        retire_data, err_illegal, err_timeout, err_divzero, instr_ready}, 1);
  endtask

  task automatic dbg_sweep();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("dbg_r%0d", i), dbg_data, m[i]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, rs, rt, f, o;
    cyc = 0; checks = 0; errors = 0; alu_lat = 0; ia_cnt = 0;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0; stray = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    do_reset();
    issue(itype(8, 0, 1, 5), 0);
    issue(itype(8, 0, 2, 7), 0);
    issue(rtype(1, 2, 3, 0, 13), 0);
    issue(itype(8, 0, 4, 16'hFFF0), 1);
    issue(itype(8, 1, 0, 9), 0);
    issue(itype(8, 0, 1, 100), 0);
    issue(rtype(1, 2, 5, 3, 12), 6);
    issue(rtype(1, 2, 6, 0, 0), 0);
    issue(itype(63, 1, 2, 1234), 0);
    drain();
    stray = 1'b1;
    @(posedge clk);
    #1;
    stray = 1'b0;
    dbg_sweep();
    issue(rtype(1, 9, 7, 0, 12), 0);
    drain();
    do_reset();
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 3);
      rs = $urandom_range(0, 31);
      rt = $urandom_range(0, 31);
      if (k == 1) begin
        f = $urandom_range(1, 13);
        if (f == 12 && m[rt] == 0) f = 13;
        issue(rtype(rs, rt, $urandom_range(0, 31), $urandom_range(0, 31), f), f == 12 ? $urandom_range(4, 8) : $urandom_range(0, 3));
      end else if (k == 2) begin
        if ($urandom_range(0, 1) == 1) begin
          o = $urandom_range(1, 63);
          if (o == 8) o = 9;
          issue(itype(o, rs, rt, $urandom), 0);
        end else begin
          f = $urandom_range(14, 64);
          issue(rtype(rs, rt, 1, 0, f == 64 ? 0 : f), 0);
        end
      end else issue(itype(8, rs, rt, $urandom), $urandom_range(0, 3));
    end
    drain();
    dbg_sweep();
    issue(itype(8, 0, 8, 50), 0);
    issue(rtype(8, 8, 9, 0, 12), 30);
    repeat (6) @(posedge clk);
    #1;
    do_reset();
    dbg_sweep();
    issue(itype(8, 0, 1, 3), 0);
    issue(rtype(1, 1, 2, 0, 13), 0);
    drain();
    dbg_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
